mem_wb_stage: RTL and testbench



---
 rtl/mem_wb_stage.sv | 148 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with big-endian load alignment and write-back.
// Optional retire counter: define MEM_WB_RETIRE_CNT_EN.
//
// Ports:
//   clk, reset        : clock, async active-high reset
//   stall, flush      : hold all state / clear valid (flush wins)
//   mem_*             : results from the memory stage
//   wb_reg_write      : register-file write enable (never for r0)
//   wb_write_reg      : register-file write address
//   wb_write_data     : aligned/extended write data (0 when not valid)
//   wb_valid          : registered valid bit
//   load_misaligned   : misaligned load held in the WB slot
//   retire_count      : (MEM_WB_RETIRE_CNT_EN only) retired instruction count
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_to_reg,
  input  logic [2:0]        mem_load_type,
  input  logic [REG_AW-1:0] mem_write_reg,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_write_reg,
  output logic [DATA_W-1:0] wb_write_data,
  output logic              wb_valid,
`ifdef MEM_WB_RETIRE_CNT_EN
  output logic [31:0]       retire_count,
`endif
  output logic              load_misaligned
);

  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  logic              valid_q, valid_d;
  logic              reg_write_q, reg_write_d;
  logic              to_reg_q, to_reg_d;
  logic [2:0]        load_type_q, load_type_d;
  logic [REG_AW-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] read_q, read_d;

  // Next-state: flush clears only valid, stall holds everything.
  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    to_reg_d    = to_reg_q;
    load_type_d = load_type_q;
    write_reg_d = write_reg_q;
    alu_d       = alu_q;
    read_d      = read_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d     = mem_valid;
      reg_write_d = mem_reg_write;
      to_reg_d    = mem_to_reg;
      load_type_d = mem_load_type;
      write_reg_d = mem_write_reg;
      alu_d       = mem_alu_result;
      read_d      = mem_read_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      to_reg_q    <= 1'b0;
      load_type_q <= '0;
      write_reg_q <= '0;
      alu_q       <= '0;
      read_q      <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      to_reg_q    <= to_reg_d;
      load_type_q <= load_type_d;
      write_reg_q <= write_reg_d;
      alu_q       <= alu_d;
      read_q      <= read_d;
    end
  end

  logic [1:0]        off;
  logic              is_b, is_h, is_sgn;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] ld_data;
  logic              misaligned;

  always_comb begin
    off    = alu_q[1:0];
    is_b   = (load_type_q == LT_LB) | (load_type_q == LT_LBU);
    is_h   = (load_type_q == LT_LH) | (load_type_q == LT_LHU);
    is_sgn = (load_type_q == LT_LB) | (load_type_q == LT_LH);
    // Big-endian: offset 0 is the most significant byte.
    unique case (off)
      2'd0:    byte_sel = read_q[31:24];
      2'd1:    byte_sel = read_q[23:16];
      2'd2:    byte_sel = read_q[15:8];
      default: byte_sel = read_q[7:0];
    endcase
    // Odd halfword offsets are flagged misaligned; off[1] picks the half.
    half_sel = off[1] ? read_q[15:0] : read_q[31:16];
    unique case (1'b1)
      is_b:    ld_data = {{(DATA_W-8){is_sgn & byte_sel[7]}}, byte_sel};
      is_h:    ld_data = {{(DATA_W-16){is_sgn & half_sel[15]}}, half_sel};
      default: ld_data = read_q;
    endcase
    misaligned = valid_q & to_reg_q &
                 ((~is_b & ~is_h & (off != 2'd0)) | (is_h & off[0]));
  end

  assign wb_valid        = valid_q;
  assign wb_write_reg    = write_reg_q;
  assign load_misaligned = misaligned;
  assign wb_reg_write    = valid_q & reg_write_q &
                           (write_reg_q != '0) & ~misaligned;
  assign wb_write_data   = valid_q ? (to_reg_q ? ld_data : alu_q) : '0;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // A retirement is a valid, non-misaligned instruction leaving WB.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_q & ~misaligned & ~stall) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign retire_count = cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: vector table, corner sequences, random vs model.
// Define MEM_WB_RETIRE_CNT_EN to also check the retire counter.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        mem_valid, mem_reg_write, mem_to_reg;
  logic [2:0]  mem_load_type;
  logic [4:0]  mem_write_reg;
  logic [31:0] mem_alu_result, mem_read_data;
  logic        wb_reg_write, wb_valid, load_misaligned;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retire_count;
`endif

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_to_reg(mem_to_reg), .mem_load_type(mem_load_type),
    .mem_write_reg(mem_write_reg), .mem_alu_result(mem_alu_result),
    .mem_read_data(mem_read_data),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data), .wb_valid(wb_valid),
`ifdef MEM_WB_RETIRE_CNT_EN
    .retire_count(retire_count),
`endif
    .load_misaligned(load_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, rw, m2r;
    logic [2:0]  lt;
    logic [4:0]  wr;
    logic [31:0] alu, rd;
  } ins_t;

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] data;
    logic        v, mis;
  } out_t;

  typedef struct {
    ins_t in;
    out_t ex;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  ins_t  m_ins;
  logic [31:0] m_cnt;

  // Reference: what the write-back port must show for a held instruction.
  function automatic out_t ref_out(ins_t s);
    out_t o;
    int off;
    logic [31:0] d, b, h;
    bit word, half, mis;
    off  = int'(s.alu % 4);
    half = (s.lt == 3) || (s.lt == 4);
    word = !half && !(s.lt == 1 || s.lt == 2);
    b = (s.rd >> (8 * (3 - off))) & 32'hFF;
    h = (s.rd >> (16 * (1 - off / 2))) & 32'hFFFF;
    if (s.lt == 1 || s.lt == 2)
      d = (s.lt == 1 && b >= 128) ? (b | 32'hFFFF_FF00) : b;
    else if (half)
      d = (s.lt == 3 && h >= 32768) ? (h | 32'hFFFF_0000) : h;
    else
      d = s.rd;
    if (!s.m2r) d = s.alu;
    mis = s.v && s.m2r && ((word && off != 0) || (half && off % 2 == 1));
    o.v    = s.v;
    o.wr   = s.wr;
    o.mis  = mis;
    o.data = s.v ? d : 32'h0;
    o.rw   = s.v && s.rw && s.wr != 0 && !mis;
    return o;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(string nm, out_t e);
    chk({nm, ".reg_write"}, 32'(wb_reg_write), 32'(e.rw));
    chk({nm, ".write_reg"}, 32'(wb_write_reg), 32'(e.wr));
    chk({nm, ".write_data"}, wb_write_data, e.data);
    chk({nm, ".valid"}, 32'(wb_valid), 32'(e.v));
    chk({nm, ".misaligned"}, 32'(load_misaligned), 32'(e.mis));
  endtask

  function automatic ins_t zero_ins();
    ins_t z;
    z = '{v:0, rw:0, m2r:0, lt:0, wr:0, alu:0, rd:0};
    return z;
  endfunction

  // One clock: drive, advance model, step past the edge.
  task automatic cycle(ins_t s, bit st, bit fl);
    out_t cur;
    mem_valid      = s.v;
    mem_reg_write  = s.rw;
    mem_to_reg     = s.m2r;
    mem_load_type  = s.lt;
    mem_write_reg  = s.wr;
    mem_alu_result = s.alu;
    mem_read_data  = s.rd;
    stall = st;
    flush = fl;
    cur = ref_out(m_ins);
    if (m_ins.v && !cur.mis && !st) m_cnt = m_cnt + 1;
    if (fl) m_ins.v = 0;
    else if (!st) m_ins = s;
    @(posedge clk);
    #1;
  endtask

  function automatic ins_t mk(logic v, logic rw, logic m2r, logic [2:0] lt,
                              logic [4:0] wr, logic [31:0] alu,
                              logic [31:0] rd);
    ins_t s;
    s = '{v:v, rw:rw, m2r:m2r, lt:lt, wr:wr, alu:alu, rd:rd};
    return s;
  endfunction

  function automatic out_t mo(logic rw, logic [4:0] wr, logic [31:0] d,
                              logic v, logic mis);
    out_t o;
    o = '{rw:rw, wr:wr, data:d, v:v, mis:mis};
    return o;
  endfunction

  vec_t tab[12];
  out_t held;
  ins_t r;

  initial begin
    tab[0]  = '{mk(1,1,0,0,5,32'h1234_5678,0), mo(1,5,32'h1234_5678,1,0)};
    tab[1]  = '{mk(1,1,1,1,6,32'h101,32'h11F2_3344), mo(1,6,32'hFFFF_FFF2,1,0)};
    tab[2]  = '{mk(1,1,1,2,6,32'h101,32'h11F2_3344), mo(1,6,32'h0000_00F2,1,0)};
    tab[3]  = '{mk(1,1,1,3,7,32'h102,32'hAAAA_8001), mo(1,7,32'hFFFF_8001,1,0)};
    tab[4]  = '{mk(1,1,1,4,7,32'h101,32'hAAAA_8001), mo(0,7,32'h0000_AAAA,1,1)};
    tab[5]  = '{mk(1,1,0,0,0,32'h7,0), mo(0,0,32'h7,1,0)};
    tab[6]  = '{mk(0,1,0,0,9,32'h55,0), mo(0,9,32'h0,0,0)};
    tab[7]  = '{mk(1,1,1,0,8,32'h100,32'hDEAD_BEEF), mo(1,8,32'hDEAD_BEEF,1,0)};
    tab[8]  = '{mk(1,1,1,0,8,32'h102,32'hDEAD_BEEF), mo(0,8,32'hDEAD_BEEF,1,1)};
    tab[9]  = '{mk(1,1,1,3,4,32'h0,32'h8001_1234), mo(1,4,32'hFFFF_8001,1,0)};
    tab[10] = '{mk(1,1,1,1,3,32'h3,32'h0000_0080), mo(1,3,32'hFFFF_FF80,1,0)};
    tab[11] = '{mk(1,1,1,7,2,32'h4,32'hCAFE_F00D), mo(1,2,32'hCAFE_F00D,1,0)};

    m_ins = zero_ins();
    m_cnt = 0;
    reset = 1'b1;
    stall = 0; flush = 0;
    mem_valid = 0; mem_reg_write = 0; mem_to_reg = 0;
    mem_load_type = 0; mem_write_reg = 0;
    mem_alu_result = 0; mem_read_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", mo(0, 0, 0, 0, 0));
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      cycle(tab[i].in, 0, 0);
      chk_out($sformatf("vec%0d", i), tab[i].ex);
    end

    // Stall three cycles with changing inputs: outputs frozen.
    cycle(mk(1,1,0,0,3,32'hA5,0), 0, 0);
    held = mo(1, 3, 32'hA5, 1, 0);
    chk_out("pre_stall", held);
    for (int i = 0; i < 3; i++) begin
      cycle(mk(1,1,0,0,5'(10+i),32'(i+100),0), 1, 0);
      chk_out($sformatf("stall%0d", i), held);
    end
    // Misaligned flag must persist while stalled.
    cycle(mk(1,1,1,0,12,32'h201,32'h1), 0, 0);
    chk_out("mis_pre", ref_out(m_ins));
    cycle(mk(1,1,0,0,13,32'h9,0), 1, 0);
    chk("mis_stall", 32'(load_misaligned), 32'd1);
    // Stall and flush together: bubble wins.
    cycle(mk(1,1,0,0,14,32'h77,0), 1, 1);
    chk("stall_flush.valid", 32'(wb_valid), 32'd0);
    chk("stall_flush.rw", 32'(wb_reg_write), 32'd0);
    chk("stall_flush.data", wb_write_data, 32'd0);

`ifdef MEM_WB_RETIRE_CNT_EN
    chk("cnt_dir", retire_count, m_cnt);
`endif

    // Reset between edges clears outputs without a clock edge.
    cycle(mk(1,1,0,0,15,32'hBEEF,0), 0, 0);
    chk_out("pre_async", mo(1, 15, 32'hBEEF, 1, 0));
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_reset", mo(0, 0, 0, 0, 0));
`ifdef MEM_WB_RETIRE_CNT_EN
    chk("async_reset.cnt", retire_count, 32'd0);
`endif
    m_ins = zero_ins();
    m_cnt = 0;
    @(negedge clk);
    reset = 1'b0;

`ifdef MEM_WB_RETIRE_CNT_EN
    // 4 valid, 1 bubble, 1 misaligned LW.
    cycle(mk(1,1,0,0,1,1,0), 0, 0);
    cycle(mk(1,0,0,0,2,2,0), 0, 0);
    cycle(mk(0,1,0,0,3,3,0), 0, 0);
    cycle(mk(1,1,1,0,4,32'h1,0), 0, 0);
    cycle(mk(1,1,0,0,5,5,0), 0, 0);
    cycle(mk(1,1,0,0,6,6,0), 0, 0);
    cycle(zero_ins(), 0, 0);
    chk("retire4", retire_count, 32'd4);
`endif

    for (int i = 0; i < 400; i++) begin
      r.v   = ($urandom_range(0, 9) != 0);
      r.rw  = ($urandom_range(0, 3) != 0);
      r.m2r = $urandom_range(0, 1);
      r.lt  = 3'($urandom_range(0, 7));
      r.wr  = 5'($urandom_range(0, 31));
      r.alu = $urandom;
      r.rd  = $urandom;
      cycle(r, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      chk_out($sformatf("rnd%0d", i), ref_out(m_ins));
`ifdef MEM_WB_RETIRE_CNT_EN
      chk($sformatf("rnd%0d.cnt", i), retire_count, m_cnt);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
